// File: rtl/freq_period_meter.sv
// freq_period_meter
// Measures the period of an asynchronous oscillator (FREQ_IN). It counts CLK
// cycles across 2**DIV_BITS rising edges and issues one OUT_VALID strobe per
// completed window. Windows run back to back, so no cycle is lost or counted
// twice.
// Optional feature: define FREQ_PERIOD_METER_TIMEOUT_EN to enable the no-edge
// timeout. It issues a strobe with OUT_VALUE all ones and OUT_TIMEOUT=1.
module freq_period_meter #(
    parameter int DATA_BITS      = 30,
    parameter int DIV_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 FREQ_IN,
    output logic [DATA_BITS-1:0] OUT_VALUE,
    output logic                 OUT_VALID,
    output logic                 OUT_TIMEOUT
);

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    localparam logic [DATA_BITS-1:0] CNT_MAX = {DATA_BITS{1'b1}};

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    logic                 w_rise;
    logic [DATA_BITS-1:0] r_cnt;
    logic [DATA_BITS-1:0] w_cnt_inc;
    logic [DIV_BITS-1:0]  r_edge_cnt;
    logic                 w_start;
    logic                 w_close;
    logic                 w_timeout;
    logic                 w_idle_hit;
    logic [DATA_BITS-1:0] r_value;
    logic                 r_valid;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= FREQ_IN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + DATA_BITS'(1);

`ifdef FREQ_PERIOD_METER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_timeout;

    assign w_idle_hit = (r_idle == IDLE_LAST);

    // Idle counter: restarts on every edge or on a timeout, counts otherwise
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idle <= '0;
        end else if (w_rise || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // Timeout flag describes the most recent strobe only
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_timeout <= 1'b1;
        end else if (w_close) begin
            r_timeout <= 1'b0;
        end
    end

    assign OUT_TIMEOUT = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_idle_hit       = 1'b0;
    assign OUT_TIMEOUT      = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= WAIT_FIRST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and window events; an edge always beats a coincident timeout
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_close      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            WAIT_FIRST: begin
                if (w_rise) begin
                    w_start      = 1'b1;
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise && (&r_edge_cnt)) begin
                    w_close = 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_FIRST;
            end
        endcase
        if (!w_rise && w_idle_hit) begin
            w_timeout    = 1'b1;
            w_start      = 1'b0;
            w_close      = 1'b0;
            w_state_next = WAIT_FIRST;
        end
    end

    // Cycle and edge counters; the closing edge reloads cnt=1 to open the next window
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
        end else if (w_timeout) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
        end else if (w_start || w_close) begin
            r_cnt      <= DATA_BITS'(1);
            r_edge_cnt <= '0;
        end else if (r_state == MEASURE) begin
            r_cnt <= w_cnt_inc;
            if (w_rise) begin
                r_edge_cnt <= r_edge_cnt + DIV_BITS'(1);
            end
        end
    end

    // Output sample register and one-cycle strobe
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_value <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_close | w_timeout;
            if (w_close) begin
                r_value <= r_cnt;
            end else if (w_timeout) begin
                r_value <= CNT_MAX;
            end
        end
    end

    assign OUT_VALUE = r_value;
    assign OUT_VALID = r_valid;

endmodule

// File: tb/tb_freq_period_meter.sv
// Directed testbench for freq_period_meter (default build, timeout disabled).
// Main instance: DATA_BITS=16, DIV_BITS=2. A second instance with DATA_BITS=8
// is driven at period 100 to exercise saturation.
module tb_freq_period_meter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        freq_main;
    logic        freq_sat;
    logic [15:0] val_main;
    logic        vld_main;
    logic        tmo_main;
    logic [7:0]  val_sat;
    logic        vld_sat;
    logic        tmo_sat;

    always #5 CLK = ~CLK;

    freq_period_meter #(.DATA_BITS(16), .DIV_BITS(2), .TIMEOUT_CYCLES(200)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .FREQ_IN(freq_main),
        .OUT_VALUE(val_main), .OUT_VALID(vld_main), .OUT_TIMEOUT(tmo_main)
    );

    freq_period_meter #(.DATA_BITS(8), .DIV_BITS(2), .TIMEOUT_CYCLES(200)) u_sat (
        .CLK(CLK), .RESET_N(RESET_N), .FREQ_IN(freq_sat),
        .OUT_VALUE(val_sat), .OUT_VALID(vld_sat), .OUT_TIMEOUT(tmo_sat)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Main input generator: period alternates per_a / per_b, high for half.
    bit gen_on  = 1'b0;
    int phase   = 0;
    int per_a   = 10;
    int per_b   = 10;
    bit use_b   = 1'b0;
    int cur_per = 10;
    int sphase  = 0;

    int rise_cyc[$];  // sample index at which a FREQ_IN high was first captured
    int q_val[$];
    int q_cyc[$];
    int q_tmo[$];
    int sq_val[$];
    int sq_tmo[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step();
        logic nxt;
        @(negedge CLK);
        if (gen_on) begin
            nxt = (phase < cur_per / 2);
            if (nxt && !freq_main) rise_cyc.push_back(cyc + 1);
            freq_main = nxt;
            phase++;
            if (phase >= cur_per) begin
                phase   = 0;
                use_b   = !use_b;
                cur_per = use_b ? per_b : per_a;
            end
        end else begin
            freq_main = 1'b0;
        end
        freq_sat = (sphase < 50);
        sphase   = (sphase + 1) % 100;
        @(posedge CLK);
        #1;
        cyc++;
        if (vld_main) begin
            q_val.push_back(int'(val_main));
            q_cyc.push_back(cyc);
            q_tmo.push_back(int'(tmo_main));
        end
        if (vld_sat) begin
            sq_val.push_back(int'(val_sat));
            sq_tmo.push_back(int'(tmo_sat));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_strobes(input string tag, input int k, input int budget);
        int n;
        n = 0;
        while (q_val.size() < k && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(q_val.size() >= k), 32'd1);
    endtask

    task automatic start_gen(input int pa, input int pb);
        phase    = 0;
        per_a    = pa;
        per_b    = pb;
        use_b    = 1'b0;
        cur_per  = pa;
        rise_cyc.delete();
        q_val.delete();
        q_cyc.delete();
        q_tmo.delete();
        gen_on   = 1'b1;
    endtask

    task automatic pulse_reset();
        gen_on = 1'b0;
        #2 RESET_N = 1'b0;
        run(3);
        RESET_N = 1'b1;
        run(5);
    endtask

    initial begin
        RESET_N   = 1'b0;
        freq_main = 1'b0;
        freq_sat  = 1'b0;
        run(4);

        // Reset state
        check("reset_value", 32'(val_main), 32'd0);
        check("reset_valid", 32'(vld_main), 32'd0);
        check("reset_timeout", 32'(tmo_main), 32'd0);
        check("reset_sat_value", 32'(val_sat), 32'd0);

        RESET_N = 1'b1;
        run(5);

        // Steady period 10: 4 periods = 40. The FREQ_IN high captured at sample c
        // is seen as rise at c+1; the 5th edge closes the window at c+41 and
        // OUT_VALID is visible one register later at c+42.
        start_gen(10, 10);
        wait_strobes("p10_strobes", 3, 300);
        check("p10_first_latency", 32'(q_cyc[0] - rise_cyc[0]), 32'd42);
        check("p10_val0", 32'(q_val[0]), 32'd40);
        check("p10_val1", 32'(q_val[1]), 32'd40);
        check("p10_val2", 32'(q_val[2]), 32'd40);
        check("p10_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd40);
        check("p10_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd40);
        check("p10_tmo", 32'(q_tmo[0]), 32'd0);

        // Async reset mid-window (two edges into the window), away from any clock edge
        run(25);
        check("pre_reset_value", 32'(val_main), 32'd40);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_value", 32'(val_main), 32'd0);
        check("async_reset_valid", 32'(vld_main), 32'd0);
        gen_on = 1'b0;
        run(3);
        RESET_N = 1'b1;
        run(5);

        // After release the first strobe follows the 5th edge (1 + N rises)
        start_gen(10, 10);
        wait_strobes("post_reset_strobe", 1, 200);
        check("post_reset_cyc", 32'(q_cyc[0]), 32'(rise_cyc[4] + 2));
        check("post_reset_val", 32'(q_val[0]), 32'd40);

        // Stuck input, no timeout feature: no strobes, value held
        gen_on = 1'b0;
        q_val.delete();
        q_cyc.delete();
        run(1000);
        check("stuck_no_strobe", 32'(q_val.size()), 32'd0);
        check("stuck_value_held", 32'(val_main), 32'd40);
        check("stuck_timeout_flag", 32'(tmo_main), 32'd0);

        // Alternating 9/11 periods: every window still spans exactly 40 CLK
        pulse_reset();
        start_gen(9, 11);
        wait_strobes("alt_strobes", 4, 400);
        check("alt_first_cyc", 32'(q_cyc[0]), 32'(rise_cyc[4] + 2));
        for (int i = 0; i < 4; i++) check($sformatf("alt_val%0d", i), 32'(q_val[i]), 32'd40);
        for (int i = 1; i < 4; i++) check($sformatf("alt_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd40);

        // Minimum resolvable period (2 CLK): 4 periods = 8
        pulse_reset();
        start_gen(2, 2);
        wait_strobes("p2_strobes", 3, 100);
        check("p2_val0", 32'(q_val[0]), 32'd8);
        check("p2_val2", 32'(q_val[2]), 32'd8);
        check("p2_gap", 32'(q_cyc[2] - q_cyc[1]), 32'd8);

        // Saturation: DATA_BITS=8, period 100 -> 400 clamps to 255, no flag
        check("sat_strobes", 32'(sq_val.size() >= 2), 32'd1);
        foreach (sq_val[i]) begin
            check($sformatf("sat_val%0d", i), 32'(sq_val[i]), 32'd255);
            check($sformatf("sat_tmo%0d", i), 32'(sq_tmo[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
